// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register file's single write port, with pending-write query.
// Optional macro WB_FWD_EN adds q_fwd1/q_fwd2 carrying the newest pending value for each query address.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_rd,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_rd,
  input  logic [DATA_W-1:0] s1_data,
  output logic              we_o,
  output logic [ADDR_W-1:0] wa_o,
  output logic [DATA_W-1:0] wd_o,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_busy1,
  output logic              q_busy2
`ifdef WB_FWD_EN
  ,
  output logic [DATA_W-1:0] q_fwd1,
  output logic [DATA_W-1:0] q_fwd2
`endif
);

  typedef enum logic {RR_S0 = 1'b0, RR_S1 = 1'b1} rr_e;

  logic              r_full0, r_full1;
  logic [ADDR_W-1:0] r_rd0, r_rd1;
  logic [DATA_W-1:0] r_data0, r_data1;
  logic              r_s1_older;
  rr_e               r_rr;
  logic              r_we;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;

  logic w_gnt0, w_gnt1, w_contested, w_load0, w_load1;

  // Equal destinations must drain oldest-first; only distinct ones consult the pointer.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_contested = r_full0 & r_full1 & (r_rd0 != r_rd1);
    if (r_full0 && r_full1) begin
      if (r_rd0 == r_rd1) begin
        w_gnt1 = r_s1_older;
        w_gnt0 = ~r_s1_older;
      end else begin
        w_gnt0 = (r_rr == RR_S0);
        w_gnt1 = (r_rr == RR_S1);
      end
    end else begin
      w_gnt0 = r_full0;
      w_gnt1 = r_full1;
    end
  end

  assign s0_ready = ~r_full0 | w_gnt0;
  assign s1_ready = ~r_full1 | w_gnt1;
  assign w_load0  = s0_valid & s0_ready & (s0_rd != '0);
  assign w_load1  = s1_valid & s1_ready & (s1_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full0    <= 1'b0;
      r_full1    <= 1'b0;
      r_rd0      <= '0;
      r_rd1      <= '0;
      r_data0    <= '0;
      r_data1    <= '0;
      r_s1_older <= 1'b0;
      r_rr       <= RR_S0;
      r_we       <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
    end else begin
      if (w_load0) begin
        r_full0 <= 1'b1;
        r_rd0   <= s0_rd;
        r_data0 <= s0_data;
      end else if (w_gnt0) begin
        r_full0 <= 1'b0;
      end
      if (w_load1) begin
        r_full1 <= 1'b1;
        r_rd1   <= s1_rd;
        r_data1 <= s1_data;
      end else if (w_gnt1) begin
        r_full1 <= 1'b0;
      end
      // A fresh load is youngest; simultaneous loads leave s0 as the older one.
      if (w_load1)      r_s1_older <= 1'b0;
      else if (w_load0) r_s1_older <= 1'b1;
      if (w_contested)  r_rr <= w_gnt0 ? RR_S1 : RR_S0;
      r_we <= w_gnt0 | w_gnt1;
      if (w_gnt0) begin
        r_wa <= r_rd0;
        r_wd <= r_data0;
      end else if (w_gnt1) begin
        r_wa <= r_rd1;
        r_wd <= r_data1;
      end
    end
  end

  assign we_o = r_we;
  assign wa_o = r_wa;
  assign wd_o = r_wd;

  function automatic logic f_busy(input logic [ADDR_W-1:0] a);
    return (a != '0) && ((r_full0 && (r_rd0 == a)) || (r_full1 && (r_rd1 == a)) ||
                         (r_we && (r_wa == a)));
  endfunction

  assign q_busy1 = f_busy(q_addr1);
  assign q_busy2 = f_busy(q_addr2);

`ifdef WB_FWD_EN
  function automatic logic [DATA_W-1:0] f_fwd(input logic [ADDR_W-1:0] a);
    logic h0, h1, hw;
    h0 = (a != '0) && r_full0 && (r_rd0 == a);
    h1 = (a != '0) && r_full1 && (r_rd1 == a);
    hw = (a != '0) && r_we && (r_wa == a);
    if (h0 && h1)  return r_s1_older ? r_data0 : r_data1;
    else if (h0)   return r_data0;
    else if (h1)   return r_data1;
    else if (hw)   return r_wd;
    else           return '0;
  endfunction

  assign q_fwd1 = f_fwd(q_addr1);
  assign q_fwd2 = f_fwd(q_addr2);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, directed sequences and random traffic
// checked against a timestamp-based reference model of the slots and output stage.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_rd, s1_rd;
  logic [31:0] s0_data, s1_data;
  logic        we_o;
  logic [4:0]  wa_o;
  logic [31:0] wd_o;
  logic [4:0]  q_addr1, q_addr2;
  logic        q_busy1, q_busy2;
`ifdef WB_FWD_EN
  logic [31:0] q_fwd1, q_fwd2;
`endif

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
    .we_o(we_o), .wa_o(wa_o), .wd_o(wd_o),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2)
`ifdef WB_FWD_EN
    , .q_fwd1(q_fwd1), .q_fwd2(q_fwd2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0; logic [4:0] a0; logic [31:0] d0;
    logic v1; logic [4:0] a1; logic [31:0] d1;
    logic [4:0] q1; logic [4:0] q2;
    logic r0; logic r1; logic we; logic [4:0] wa; logic [31:0] wd; logic b1; logic [31:0] f1;
  } vec_t;

  vec_t tbl [18];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each slot remembers when it was loaded; older = smaller stamp.
  bit          m_full [2];
  logic [4:0]  m_rd   [2];
  logic [31:0] m_data [2];
  int          m_stamp[2];
  int          m_rr;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_rd[i] = '0; m_data[i] = '0; m_stamp[i] = 0;
    end
    m_rr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
  endtask

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    for (int i = 0; i < 2; i++) if (m_full[i] && m_rd[i] == a) return 1'b1;
    return m_we && (m_wa == a);
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] a);
    int best;
    best = -1;
    if (a == 5'd0) return 32'h0;
    for (int i = 0; i < 2; i++)
      if (m_full[i] && m_rd[i] == a && (best < 0 || m_stamp[i] > m_stamp[best])) best = i;
    if (best >= 0) return m_data[best];
    if (m_we && m_wa == a) return m_wd;
    return 32'h0;
  endfunction

  // Called one time unit after a rising edge; returns one time unit after the next one.
  task automatic step(input vec_t v, input bit tbl_chk);
    int g; bit contested; logic r0, r1;
    s0_valid = v.v0; s0_rd = v.a0; s0_data = v.d0;
    s1_valid = v.v1; s1_rd = v.a1; s1_data = v.d1;
    q_addr1 = v.q1; q_addr2 = v.q2;
    #1;
    g = -1; contested = 0;
    if (m_full[0] && m_full[1]) begin
      if (m_rd[0] == m_rd[1]) g = (m_stamp[0] < m_stamp[1]) ? 0 : 1;
      else begin g = m_rr; contested = 1; end
    end else if (m_full[0]) g = 0;
    else if (m_full[1]) g = 1;
    r0 = !m_full[0] || g == 0;
    r1 = !m_full[1] || g == 1;
    chk("s0_ready", 32'(s0_ready), 32'(r0));
    chk("s1_ready", 32'(s1_ready), 32'(r1));
    chk("we_o", 32'(we_o), 32'(m_we));
    chk("wa_o", 32'(wa_o), 32'(m_wa));
    chk("wd_o", wd_o, m_wd);
    chk("q_busy1", 32'(q_busy1), 32'(exp_busy(v.q1)));
    chk("q_busy2", 32'(q_busy2), 32'(exp_busy(v.q2)));
`ifdef WB_FWD_EN
    chk("q_fwd1", q_fwd1, exp_fwd(v.q1));
    chk("q_fwd2", q_fwd2, exp_fwd(v.q2));
`endif
    if (tbl_chk) begin
      chk("tbl_s0_ready", 32'(s0_ready), 32'(v.r0));
      chk("tbl_s1_ready", 32'(s1_ready), 32'(v.r1));
      chk("tbl_we", 32'(we_o), 32'(v.we));
      chk("tbl_wa", 32'(wa_o), 32'(v.wa));
      chk("tbl_wd", wd_o, v.wd);
      chk("tbl_busy1", 32'(q_busy1), 32'(v.b1));
`ifdef WB_FWD_EN
      chk("tbl_fwd1", q_fwd1, v.f1);
`endif
    end
    @(posedge clk); #1;
    cyc++;
    if (contested) m_rr = 1 - g;
    m_we = (g >= 0);
    if (g >= 0) begin
      m_wa = m_rd[g]; m_wd = m_data[g]; m_full[g] = 0;
    end
    if (v.v0 && r0 && v.a0 != 5'd0) begin
      m_full[0] = 1; m_rd[0] = v.a0; m_data[0] = v.d0; m_stamp[0] = cyc * 2;
    end
    if (v.v1 && r1 && v.a1 != 5'd0) begin
      m_full[1] = 1; m_rd[1] = v.a1; m_data[1] = v.d1; m_stamp[1] = cyc * 2 + 1;
    end
  endtask

  function automatic vec_t mkin(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] q1, input logic [4:0] q2);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.q1 = q1; v.q2 = q2;
    v.r0 = 1'b0; v.r1 = 1'b0; v.we = 1'b0; v.wa = '0; v.wd = '0; v.b1 = 1'b0; v.f1 = '0;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //               v0   a0     d0            v1   a1     d1            q1     q2    r0   r1   we   wa     wd            b1   f1
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h1111,     5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 5'd7, 32'h2222,     1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 32'h1111};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1111,     1'b1, 32'h2222};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h2222,     1'b1, 32'h2222};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h2222,     1'b0, 32'h0};
    tbl[9]  = '{1'b1, 5'd9, 32'hA0,       1'b1, 5'd9, 32'hB0,       5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h2222,     1'b0, 32'h0};
    tbl[10] = '{1'b1, 5'd9, 32'hC0,       1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h2222,     1'b1, 32'hB0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 32'hA0,       1'b1, 32'hC0};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 32'hB0,       1'b1, 32'hC0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 32'hC0,       1'b1, 32'hC0};
    tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 5'd9, 32'hC0,       1'b0, 32'h0};
    tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd9, 32'hC0,       1'b0, 32'h0};
    tbl[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd9, 32'hC0,       1'b0, 32'h0};
    tbl[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd9, 32'hC0,       1'b0, 32'h0};

    rst = 1'b0; cyc = 0;
    s0_valid = 1'b0; s0_rd = '0; s0_data = '0;
    s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
    q_addr1 = '0; q_addr2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we", 32'(we_o), 32'h0);
    chk("reset_wa", 32'(wa_o), 32'h0);
    chk("reset_wd", wd_o, 32'h0);
    chk("reset_s0_ready", 32'(s0_ready), 32'h1);
    chk("reset_s1_ready", 32'(s1_ready), 32'h1);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) step(tbl[i], 1'b1);

    // Contention: both sources valid every cycle, grants must alternate.
    for (int i = 0; i < 10; i++) begin
      step(mkin(1'b1, 5'(1 + i), $urandom, 1'b1, 5'(17 + i), $urandom, 5'(1 + i), 5'(17 + i)), 1'b0);
      if (i >= 1) chk("contend_ready_alt", 32'(s0_ready ^ s1_ready), 32'h1);
    end

    // Asynchronous reset mid-stream with both slots full.
    q_addr1 = m_rd[0]; q_addr2 = m_rd[1];
    #1 rst = 1'b0;
    #1;
    chk("areset_we", 32'(we_o), 32'h0);
    chk("areset_wa", 32'(wa_o), 32'h0);
    chk("areset_wd", wd_o, 32'h0);
    chk("areset_s0_ready", 32'(s0_ready), 32'h1);
    chk("areset_s1_ready", 32'(s1_ready), 32'h1);
    chk("areset_busy1", 32'(q_busy1), 32'h0);
    chk("areset_busy2", 32'(q_busy2), 32'h0);
    model_reset();
    s0_valid = 1'b0; s1_valid = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back streaming from s0 alone.
    for (int t = 0; t < 7; t++) begin
      if (t >= 2 && t <= 5) begin
        chk("b2b_we", 32'(we_o), 32'h1);
        chk("b2b_wa", 32'(wa_o), 32'(t - 1));
      end
      if (t == 6) chk("b2b_we_end", 32'(we_o), 32'h0);
      if (t < 4) step(mkin(1'b1, 5'(t + 1), 32'h100 + 32'(t), 1'b0, 5'd0, 32'h0, 5'(t + 1), 5'd0), 1'b0);
      else       step(mkin(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4), 1'b0);
    end

    // Random traffic over a small register range to force address collisions.
    for (int i = 0; i < 400; i++) begin
      v = mkin(1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
               1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
               5'($urandom_range(7)), 5'($urandom_range(7)));
      step(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (WE3/A3/WD3) between two writeback sources: s0 = ALU/immediate results, s1 = load/multi-cycle unit results.
- Each source gets a one-entry holding slot with a valid/ready handshake.
- A round-robin, age-aware arbiter drains the slots into a registered write stage.
- Also provides a pending-write (busy) query for the decode stage's two source registers.

Parameters:
DATA_W, 32, data width
ADDR_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
s0_valid  in  1  source 0 write request
s0_ready  out  1  source 0 slot can accept
s0_rd  in  ADDR_W  source 0 destination register
s0_data  in  DATA_W  source 0 write data
s1_valid  in  1  source 1 write request
s1_ready  out  1  source 1 slot can accept
s1_rd  in  ADDR_W  source 1 destination register
s1_data  in  DATA_W  source 1 write data
we_o  out  1  to register file WE3
wa_o  out  ADDR_W  to register file A3
wd_o  out  DATA_W  to register file WD3
q_addr1  in  ADDR_W  busy query address 1 (decode rs1)
q_addr2  in  ADDR_W  busy query address 2 (decode rs2)
q_busy1  out  1  pending write to q_addr1
q_busy2  out  1  pending write to q_addr2

Behaviour:
- Reset (rst low, async):
  - both slots empty, we_o=0, wa_o=0, wd_o=0;
  - round-robin pointer = s0, age flag cleared;
  - all pending writes discarded;
  - the first rising edge after rst goes high is a normal cycle.
- Handshake:
  - transfer occurs when sN_valid & sN_ready at a rising edge.
  - sN_ready = slot empty OR slot granted this cycle (combinational, no dependence on sN_valid).
  - sN_rd/sN_data are sampled only on transfer.
- rd = 0: the transfer completes, but the slot is not loaded. It never reaches we_o and never sets busy.
- Age tracking:
  - on load, a slot is marked younger than any slot already full.
  - if both slots load at the same edge, s0 is older.
- Arbitration each cycle among full slots:
  - one full: grant it.
  - both full, same rd: grant the older slot (preserves write order to that register).
  - both full, different rd: grant the slot the round-robin pointer selects; the pointer then moves to the other source. The pointer changes only on a contested grant.
- Output stage (registered):
  - on grant: we_o<=1, wa_o<=slot rd, wd_o<=slot data; the slot empties at the same edge.
  - no grant: we_o<=0; wa_o/wd_o hold their previous values.
- Latency:
  - transfer at edge k → we_o high in the cycle after edge k+1 → register file written at edge k+2.
  - minimum 2 cycles when uncontested.
  - sustained throughput is 1 write/cycle total; each source gets ≥1 of every 2 cycles under contention.
- A granted slot may be reloaded by the same source at the same edge (back-to-back streaming).
- Busy query (combinational) for each qN_addr:
  - busy = (qN_addr≠0) AND (matches rd of any full slot OR (we_o AND wa_o==qN_addr)).
  - q_addr=0 never reports busy.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - adds outputs q_fwd1, q_fwd2 (DATA_W) carrying the newest pending value for qN_addr.
  - priority: younger full slot > older full slot > output stage (we_o=1).
  - qN_fwd = 0 when qN_busy = 0.
- Undefined: these ports and their logic are absent; busy reporting is unchanged.

Test Plan:
- Reset: assert rst low mid-stream with both slots full → we_o=0, wa_o=0, wd_o=0, s0_ready=s1_ready=1, q_busy1=q_busy2=0 immediately, without waiting for a clock edge.
- Single write: s0 rd=5, data=0xDEADBEEF accepted at edge k → we_o=1, wa_o=5, wd_o=0xDEADBEEF after edge k+1 only; q_busy1=1 for q_addr1=5 from edge k until we_o deasserts.
- Contention: both valid every cycle, s0 rd=1.., s1 rd=17.. → grants alternate s0,s1,s0,s1; each ready toggles; no transfer lost or duplicated.
- Same-rd ordering:
  - s1 rd=7 data=0x1111 at edge k, s0 rd=7 data=0x2222 at edge k+1 → writes occur 0x1111 then 0x2222;
  - with WB_FWD_EN, q_fwd1 for q_addr1=7 = 0x2222 while both are pending.
- x0 drop: s1 rd=0 data=0xFFFFFFFF → handshake completes, we_o stays 0, q_busy for addr 0 stays 0.
- Back-to-back: s0 streams 4 writes (rd=1..4) with s1 idle → s0_ready held 1; we_o high 4 consecutive cycles with wa_o=1,2,3,4.
